// File: rtl/adder_sweep_pkg.sv
// Shared types and width helpers for the adder sweep checker.
package adder_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Supported operand widths
    localparam int W_MIN = 1;
    localparam int W_MAX = 8;

    // A test vector packs a, b and c_in into 2W+1 bits
    function automatic int vec_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/adder_sweep_checker_ripple_adder.sv
// ripple_adder: W full-adder cells chained through their carries.
// Purely combinational; the caller registers the result.
module ripple_adder #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_c;

    assign w_c[0] = i_cin;

    // One full-adder cell per bit; carry ripples from bit 0 upward
    for (genvar g = 0; g < W; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[W];

endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive self-test of a W-bit ripple-carry adder.
// A counter walks every (a, b, c_in) vector, the adder result is registered
// next to a behavioural reference, and mismatches are counted (saturating)
// with the first failing vector captured.
// Optional build macro ADDER_SWEEP_FAULT_INJ_EN adds i_fault_en, which forces
// adder sum bit 0 to 0 ahead of the result register.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | issuing one vector per enabled cycle
// DRAIN | last result in flight, its compare lands on exit
// DONE  | sweep finished, statistics stable, start re-arms
module adder_sweep_checker
    import adder_sweep_pkg::*;
#(
    parameter int W    = 2,
    parameter int ERRW = 8
) (
    input  logic                        i_clock,
    input  logic                        i_clear,
    input  logic                        i_start,
    input  logic                        i_step_en,
`ifdef ADDER_SWEEP_FAULT_INJ_EN
    input  logic                        i_fault_en,
`endif
    output logic                        o_busy,
    output logic                        o_done,
    output logic [vec_width(W)-1:0]     o_vec,
    output logic [W-1:0]                o_sum,
    output logic                        o_carry,
    output logic                        o_valid,
    output logic [ERRW-1:0]             o_err_cnt,
    output logic [vec_width(W)-1:0]     o_first_err_vec,
    output logic                        o_first_err_valid
);

    localparam int VW = vec_width(W);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [VW-1:0]   r_vec;
    logic [VW-1:0]   r_res_vec;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic [W:0]      r_exp;
    logic            r_valid;
    logic [ERRW-1:0] r_err_cnt;
    logic [VW-1:0]   r_first_err_vec;
    logic            r_first_err_valid;

    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_cin;
    logic [W-1:0]    w_sum_raw;
    logic [W-1:0]    w_sum;
    logic            w_cout;
    logic [W:0]      w_exp;
    logic [W-1:0]    w_sum_mask;
    logic            w_mismatch;

    assign w_a   = r_vec[W-1:0];
    assign w_b   = r_vec[2*W-1:W];
    assign w_cin = r_vec[2*W];

    ripple_adder #(.W(W)) u_adder (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum_raw),
        .o_cout (w_cout)
    );

    // Mask applied to the adder sum; only bit 0 can be knocked out
    always_comb begin
        w_sum_mask = '1;
`ifdef ADDER_SWEEP_FAULT_INJ_EN
        w_sum_mask[0] = ~i_fault_en;
`endif
    end

    assign w_sum = w_sum_raw & w_sum_mask;

    // Reference is the full W+1-bit sum, never truncated
    assign w_exp = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};

    assign w_mismatch = r_valid && ({r_carry, r_sum} != r_exp);

    // Sweep FSM, vector counter, result registers and error statistics
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state           <= IDLE;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_vec             <= '0;
            r_res_vec         <= '0;
            r_sum             <= '0;
            r_carry           <= 1'b0;
            r_exp             <= '0;
            r_valid           <= 1'b0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Checker: acts on the result registered on the previous edge
            if (w_mismatch) begin
                if (r_err_cnt != '1)
                    r_err_cnt <= r_err_cnt + ERRW'(1);
                if (!r_first_err_valid) begin
                    r_first_err_vec   <= r_res_vec;
                    r_first_err_valid <= 1'b1;
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state           <= RUN;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_vec             <= '0;
                        r_err_cnt         <= '0;
                        r_first_err_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_step_en) begin
                        r_sum     <= w_sum;
                        r_carry   <= w_cout;
                        r_exp     <= w_exp;
                        r_res_vec <= r_vec;
                        r_valid   <= 1'b1;
                        if (r_vec == '1)
                            r_state <= DRAIN;
                        else
                            r_vec <= r_vec + VW'(1);
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_vec             = r_vec;
    assign o_sum             = r_sum;
    assign o_carry           = r_carry;
    assign o_valid           = r_valid;
    assign o_err_cnt         = r_err_cnt;
    assign o_first_err_vec   = r_first_err_vec;
    assign o_first_err_valid = r_first_err_valid;

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Parametrised exhaustive self-test engine for a W-bit ripple-carry adder. An internal up-counter sweeps every (a, b, c_in) combination. Each vector drives a chain of W full-adder cells, and the adder's sum/carry are registered. Each registered result is compared against a behavioural a+b+c_in reference, with error statistics accumulated. It generalises the 3-bit counter-driven single full-adder arrangement to arbitrary width, adding a start/done handshake, pause control and result checking.

## Interface
- W, default 2: operand width in bits (1..8); vector width VW = 2W+1.
- ERRW, default 8: error-counter width.
- clock  in  1  sole clock, rising edge.
- clear  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled request to begin a sweep; honoured only in IDLE or DONE.
- step_en  in  1  1 = advance one vector per cycle in RUN; 0 = pause.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- vec  out  VW  vector currently applied: a=vec[W-1:0], b=vec[2W-1:W], c_in=vec[2W].
- sum  out  W  registered adder sum.
- carry  out  1  registered adder carry-out.
- valid  out  1  sum/carry hold a freshly registered result this cycle.
- err_cnt  out  ERRW  mismatches in current sweep, saturating at 2^ERRW-1.
- first_err_vec  out  VW  vector of first mismatch in current sweep.
- first_err_valid  out  1  first_err_vec is meaningful.

## Operation
- Reset (clear low, any time, including mid-sweep): state IDLE; all outputs and internal registers 0.
- States and transitions:
  - IDLE: start=1 → RUN; vec←0, err_cnt←0, first_err_valid←0.
  - RUN with step_en=1:
    - Adder result for vec is registered into sum/carry with valid←1.
    - Expected value {carry,sum} = a+b+c_in (W+1 bits, no truncation) is registered alongside.
    - If vec is all-ones → DRAIN; otherwise vec←vec+1.
  - RUN with step_en=0: vec holds; valid←0; no compare.
  - DRAIN: one cycle with no new vector issued → DONE.
  - DONE: holds indefinitely. start=1 → RUN with the same clears as IDLE.
- start while busy: ignored.
- Compare: when valid=1 and registered {carry,sum} ≠ registered expected:
  - err_cnt increments on the next edge; at max it holds.
  - If first_err_valid=0, first_err_vec←the vector that produced the result and first_err_valid←1.
  - The compare for the last vector completes on the DRAIN→DONE edge.
- vec stays at all-ones in DRAIN/DONE until restarted.

## Timing
- Result latency: 1 cycle, vector applied → sum/carry/valid.
- Error-statistics latency: 1 further cycle.
- start sampled at edge k (IDLE) gives:
  - vec=0 after edge k.
  - First valid after edge k+1.
  - DRAIN after edge k+2^VW.
  - done=1 after edge k+2^VW+1, with step_en held high throughout.
- Each step_en=0 cycle in RUN extends the sweep by exactly one cycle.
- busy and done are never high together.

## Configuration
- ADDER_SWEEP_FAULT_INJ_EN defined:
  - Adds input port fault_en (1 bit, after step_en).
  - While fault_en=1, adder sum bit 0 is forced to 0 before the result register (stuck-at-0); the expected path is unaffected.
- Undefined: the port is absent and the adder output is unmodified.

## Structure
- Package adder_sweep_pkg holds:
  - State enum: IDLE, RUN, DRAIN, DONE.
  - Width helper constants.
- One sub-module, ripple_adder #(W): generate-chain of W full-adder cells; carry-in from vec[2W]; purely combinational.
- Counter, FSM, registers and checker live in adder_sweep_checker.

## Test plan
- Reset mid-sweep:
  - W=2, start, then clear low at vec=10 → all outputs 0 immediately, state IDLE.
  - After release, a new start runs a full 32-vector sweep.
- Clean sweep:
  - W=2, step_en=1 → done rises 33 cycles after the start edge.
  - err_cnt=0, first_err_valid=0, vec=31 at done.
- Pause:
  - W=2, step_en low for 5 cycles mid-run → done 5 cycles later than the clean case.
  - valid=0 exactly those 5 cycles; err_cnt=0.
- Fault injection (ADDER_SWEEP_FAULT_INJ_EN defined):
  - W=2, fault_en=1 → err_cnt=16, first_err_vec=1, first_err_valid=1.
- Saturation, restart and ignored start:
  - W=4, ERRW=4, fault_en=1 → err_cnt saturates at 15.
  - start in DONE clears err_cnt to 0 and re-sweeps 512 vectors.
  - start pulses during RUN have no effect.
